// File: rtl/bin_thresh_ctrl.sv
// Binarization threshold controller: per-frame luminance mean (or manual value)
// plus signed offset, loaded into thr only at frame boundaries.
//
// state | meaning
// IDLE  | accumulating pixels, waiting for a frame boundary
// DIV   | 8-cycle restoring division sum / cnt, quotient MSB first
// APPLY | add offset, clamp to 0..255, load thr
module bin_thresh_ctrl #(
  parameter int DEFAULT_THR = 30,
  parameter int CNT_W       = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pre_frame_vsync,
  input  logic       pre_frame_de,
  input  logic [7:0] color,
  input  logic       auto_en,
  input  logic [7:0] manual_thr,
  input  logic [7:0] thr_offset,
  output logic [7:0] thr,
  output logic       thr_upd,
  output logic       busy,
  output logic       ovf
);

  localparam int SUM_W = CNT_W + 8;

  typedef enum logic [1:0] {IDLE, DIV, APPLY} state_t;

  state_t           state, state_nxt;
  logic             vsync_q;
  logic             fb;
  logic [CNT_W-1:0] cnt;
  logic [SUM_W-1:0] sum;
  logic             cnt_sat;
  logic             start;
  logic             manual_load;
  logic [SUM_W-1:0] rem;
  logic [SUM_W-1:0] dvs;
  logic [7:0]       quo;
  logic [2:0]       iter;
  logic [9:0]       thr_sum;
  logic [7:0]       thr_clamp;
  logic             load_q;

  assign fb          = pre_frame_vsync & ~vsync_q;
  assign cnt_sat     = &cnt;
  assign start       = fb && (state == IDLE) && auto_en && (cnt != '0);
  assign manual_load = fb && (state == IDLE) && !auto_en;

  // 10-bit wrap of unsigned mean plus sign-extended offset; bit 9 = negative, bit 8 = above 255
  assign thr_sum = {2'b00, quo} + {{2{thr_offset[7]}}, thr_offset};

  always_comb begin
    thr_clamp = thr_sum[7:0];
    if (thr_sum[9])      thr_clamp = 8'h00;
    else if (thr_sum[8]) thr_clamp = 8'hFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vsync_q <= 1'b0;
    else        vsync_q <= pre_frame_vsync;
  end

  // A pixel arriving in the boundary cycle opens the new frame's statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sum <= '0;
    end else if (fb) begin
      cnt <= pre_frame_de ? CNT_W'(1) : '0;
      sum <= pre_frame_de ? SUM_W'(color) : '0;
    end else if (pre_frame_de && !cnt_sat) begin
      cnt <= cnt + CNT_W'(1);
      sum <= sum + SUM_W'(color);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = DIV;
      DIV:     if (iter == 3'd7) state_nxt = APPLY;
      APPLY:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // Divisor is pre-shifted by 7 and walked right, so each step compares rem with cnt<<k
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem  <= '0;
      dvs  <= '0;
      quo  <= '0;
      iter <= '0;
    end else if (start) begin
      rem  <= sum;
      dvs  <= {1'b0, cnt, 7'b0};
      quo  <= '0;
      iter <= '0;
    end else if (state == DIV) begin
      if (rem >= dvs) begin
        rem <= rem - dvs;
        quo <= {quo[6:0], 1'b1};
      end else begin
        quo <= {quo[6:0], 1'b0};
      end
      dvs  <= dvs >> 1;
      iter <= iter + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thr     <= 8'(DEFAULT_THR);
      load_q  <= 1'b0;
      thr_upd <= 1'b0;
    end else begin
      load_q  <= manual_load || (state == APPLY);
      thr_upd <= load_q;
      if (manual_load)         thr <= manual_thr;
      else if (state == APPLY) thr <= thr_clamp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           ovf <= 1'b0;
    else if ((fb && busy) || cnt_sat)     ovf <= 1'b1;
  end

endmodule
